// File: rtl/sparse_pos_loader.sv
// sparse_pos_loader
// Front end of the sparse polynomial multiplier. It accepts the WEIGHT real
// nonzero positions of the sparse operand over a valid/ready stream and
// range-checks each one against N. Accepted positions go into the position
// RAM. The RAM is then padded up to MAX_WEIGHT entries with LFSR-generated
// dummy positions. This lets the multiplier always iterate over a fixed
// number of entries.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      load request, honoured in IDLE/DONE/ERR only
//   seed_i       dummy-LFSR seed, captured with an accepted start_i (0 -> 1)
//   pos_valid_i  a real position is presented on pos_i
//   pos_i        real position value
//   pos_ready_o  high in LOAD only (combinational decode of state)
//   ram_wr_en_o  registered position-RAM write strobe
//   ram_addr_o   registered position-RAM address
//   ram_wdata_o  registered write data, bit LOGW = dummy flag
//   busy_o       high in LOAD and PAD
//   done_o       high in DONE
//   error_o      high in ERR (out-of-range position seen)
module sparse_pos_loader #(
  parameter int MAX_WEIGHT = 75,
  parameter int WEIGHT     = 66,
  parameter int N          = 17669,
  parameter int LOGW       = 16,
  parameter int LFSR_W     = 15,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              pos_valid_i,
  input  logic [LOGW-1:0]   pos_i,
  output logic              pos_ready_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [LOGW:0]     ram_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PAD  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic                w_wr_en;
  logic [LOGW:0]       w_wdata;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [LOGW:0]       r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  // Fibonacci LFSR step: shift left and feed back the XOR of the two MSBs.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_W-2]};
  endfunction

  // Map an LFSR value into [0, N). Because N > 2^(LFSR_W-1), a single
  // subtraction always lands in range.
  function automatic logic [LOGW-1:0] fold_to_n(input logic [LFSR_W-1:0] v);
    logic [LOGW-1:0] ext;
    ext = LOGW'(v);
    if (ext < LOGW'(N)) begin
      return ext;
    end else begin
      return ext - LOGW'(N);
    end
  endfunction

  // Ready is only offered while collecting real positions.
  assign pos_ready_o = (r_state == S_LOAD);

  // Next-state, counter, LFSR and write-request logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_wr_en     = 1'b0;
    w_wdata     = {(LOGW+1){1'b0}};
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = {ADDR_W{1'b0}};
          if (seed_i == {LFSR_W{1'b0}}) begin
            w_lfsr_nxt = {{(LFSR_W-1){1'b0}}, 1'b1};
          end else begin
            w_lfsr_nxt = seed_i;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LOAD: begin
        if (pos_valid_i) begin
          if (pos_i < LOGW'(N)) begin
            w_wr_en   = 1'b1;
            w_wdata   = {1'b0, pos_i};
            w_cnt_nxt = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (r_cnt == ADDR_W'(WEIGHT - 1)) begin
              if (WEIGHT == MAX_WEIGHT) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_PAD;
              end
            end else begin
              w_state_nxt = S_LOAD;
            end
          end else begin
            // Out-of-range position: no write, counter frozen.
            w_state_nxt = S_ERR;
          end
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_PAD: begin
        w_wr_en    = 1'b1;
        w_wdata    = {1'b1, fold_to_n(r_lfsr)};
        w_lfsr_nxt = lfsr_step(r_lfsr);
        w_cnt_nxt  = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (r_cnt == ADDR_W'(MAX_WEIGHT - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_PAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, LFSR and registered output updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {ADDR_W{1'b0}};
      r_lfsr  <= {{(LFSR_W-1){1'b0}}, 1'b1};
      r_wr_en <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {(LOGW+1){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_wr_en <= w_wr_en;
      // The write uses the pre-increment counter as its address.
      r_addr  <= w_wr_en ? r_cnt : {ADDR_W{1'b0}};
      r_wdata <= w_wdata;
      r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_PAD);
      r_done  <= (w_state_nxt == S_DONE);
      r_error <= (w_state_nxt == S_ERR);
    end
  end

  assign ram_wr_en_o = r_wr_en;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = r_wdata;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign error_o     = r_error;

endmodule

// File: tb/tb_sparse_pos_loader.sv
module tb_sparse_pos_loader;
  localparam int MAXW = 75;
  localparam int WT   = 66;
  localparam int NN   = 17669;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [14:0] seed_i = 15'd0;
  logic        pos_valid_i = 1'b0;
  logic [15:0] pos_i = 16'd0;
  logic        pos_ready_o, ram_wr_en_o, busy_o, done_o, error_o;
  logic [6:0]  ram_addr_o;
  logic [16:0] ram_wdata_o;

  sparse_pos_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i),
    .pos_valid_i(pos_valid_i), .pos_i(pos_i), .pos_ready_o(pos_ready_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Captured writes and accepts
  int          w_cyc[$];
  int          w_addr[$];
  logic [16:0] w_data[$];
  int          acc_q[$];
  logic [16:0] exp_data[$];

  always @(negedge clk) begin
    if (rst_n && ram_wr_en_o) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(int'(ram_addr_o));
      w_data.push_back(ram_wdata_o);
    end
  end

  task automatic clear_cap();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); acc_q.delete();
  endtask

  // Reference: real positions in order, then MAXW-WT dummies from the seed.
  task automatic build_exp(input logic [14:0] seed, input logic [15:0] pq[$]);
    int l;
    int d;
    exp_data.delete();
    for (int i = 0; i < WT; i++) exp_data.push_back({1'b0, pq[i]});
    l = (seed == 15'd0) ? 1 : int'(seed);
    for (int k = WT; k < MAXW; k++) begin
      d = (l < NN) ? l : l - NN;
      exp_data.push_back({1'b1, 16'(d)});
      l = ((l << 1) & 32'h7FFF) | (((l >> 14) ^ (l >> 13)) & 1);
    end
  endtask

  task automatic pulse_start(input logic [14:0] s);
    start_i = 1'b1; seed_i = s;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // mode 0: back-to-back, 1: alternate valid, 2: random gaps
  task automatic feed(input logic [15:0] pq[$], input int mode);
    int  i = 0;
    int  guard = 0;
    bit  v;
    bit  tog = 1'b1;
    while (i < pq.size() && guard < 5000) begin
      guard++;
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      pos_valid_i = v; pos_i = pq[i];
      @(negedge clk);
      if (v && pos_ready_o) begin
        acc_q.push_back(cyc);
        i++;
      end
      @(posedge clk); #1;
    end
    pos_valid_i = 1'b0;
    checks++;
    if (guard >= 5000) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d required %0d", i, pq.size());
    end
  endtask

  task automatic wait_end();
    int g = 0;
    while (!(done_o || error_o) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (g >= 300) begin
      errors++;
      $display("FAIL end_timeout: done=%0b error=%0b required done or error", done_o, error_o);
    end
  endtask

  task automatic rand_positions(output logic [15:0] pq[$], input int n);
    pq.delete();
    for (int i = 0; i < n; i++) pq.push_back(16'($urandom_range(0, NN - 1)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({pos_ready_o, ram_wr_en_o, ram_addr_o, ram_wdata_o, busy_o, done_o, error_o} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {pos_ready_o, ram_wr_en_o, ram_addr_o, ram_wdata_o, busy_o, done_o, error_o});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] pq[$];
    pq.delete();
    for (int i = 0; i < WT; i++) pq.push_back(16'(i));
    build_exp(15'd1, pq);
    clear_cap();
    pulse_start(15'd1);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL basic_busy: busy=%0b done=%0b required 1 0", busy_o, done_o);
    end
    feed(pq, 0);
    wait_end();
    checks++;
    if (w_addr.size() !== MAXW) begin
      errors++; $display("FAIL basic_count: got %0d writes required %0d", w_addr.size(), MAXW);
    end
    for (int i = 0; i < w_addr.size() && i < MAXW; i++) begin
      checks++;
      if (w_addr[i] !== i || w_data[i] !== exp_data[i] ||
          w_cyc[i] !== ((i < WT) ? acc_q[i] + 1 : w_cyc[i-1] + 1)) begin
        errors++;
        $display("FAIL basic_write[%0d]: addr=%0d data=%h cyc=%0d required addr=%0d data=%h",
                 i, w_addr[i], w_data[i], w_cyc[i], i, exp_data[i]);
      end
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || error_o !== 1'b0 || ram_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%0b busy=%0b err=%0b wr=%0b required 1 0 0 0",
                         done_o, busy_o, error_o, ram_wr_en_o);
    end
  endtask

  task automatic test_seed_max();
    logic [15:0] pq[$];
    rand_positions(pq, WT);
    clear_cap();
    pulse_start(15'h7FFF);
    feed(pq, 2);
    wait_end();
    checks++;
    if (w_addr.size() !== MAXW) begin
      errors++; $display("FAIL seedmax_count: got %0d required %0d", w_addr.size(), MAXW);
    end else begin
      checks++;
      if (w_data[WT] !== {1'b1, 16'd15098} || w_data[WT+1] !== {1'b1, 16'd15097}) begin
        errors++; $display("FAIL seedmax_dummy: got %h %h required %h %h",
                           w_data[WT], w_data[WT+1], {1'b1, 16'd15098}, {1'b1, 16'd15097});
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] pq[$];
    logic [14:0] s;
    pq.delete();
    for (int i = 0; i < WT; i++) pq.push_back((i % 2 == 0) ? 16'd17668 : 16'd0);
    s = 15'($urandom);
    build_exp(s, pq);
    clear_cap();
    pulse_start(s);
    feed(pq, 1);
    wait_end();
    checks++;
    if (w_addr.size() !== MAXW) begin
      errors++; $display("FAIL gaps_count: got %0d required %0d", w_addr.size(), MAXW);
    end
    for (int i = 0; i < w_addr.size() && i < MAXW; i++) begin
      checks++;
      if (w_addr[i] !== i || w_data[i] !== exp_data[i] ||
          w_cyc[i] !== ((i < WT) ? acc_q[i] + 1 : w_cyc[i-1] + 1)) begin
        errors++;
        $display("FAIL gaps_write[%0d]: addr=%0d data=%h cyc=%0d required addr=%0d data=%h",
                 i, w_addr[i], w_data[i], w_cyc[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [15:0] pq[$];
    rand_positions(pq, 9);
    pq.push_back(16'd17669);
    clear_cap();
    pulse_start(15'd3);
    feed(pq, 0);
    wait_end();
    checks++;
    if (error_o !== 1'b1 || pos_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL err_flags: err=%0b rdy=%0b busy=%0b done=%0b required 1 0 0 0",
                         error_o, pos_ready_o, busy_o, done_o);
    end
    checks++;
    if (w_addr.size() !== 9) begin
      errors++; $display("FAIL err_count: got %0d writes required 9", w_addr.size());
    end
    for (int i = 0; i < w_addr.size() && i < 9; i++) begin
      checks++;
      if (w_addr[i] !== i || w_data[i] !== {1'b0, pq[i]}) begin
        errors++; $display("FAIL err_write[%0d]: addr=%0d data=%h required %0d %h",
                           i, w_addr[i], w_data[i], i, {1'b0, pq[i]});
      end
    end
    // Restart from ERR
    rand_positions(pq, WT);
    build_exp(15'd0, pq);
    clear_cap();
    pulse_start(15'd0);
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL err_restart: err=%0b busy=%0b required 0 1", error_o, busy_o);
    end
    feed(pq, 2);
    wait_end();
    checks++;
    if (w_addr.size() !== MAXW || done_o !== 1'b1) begin
      errors++; $display("FAIL err_reload: writes=%0d done=%0b required %0d 1", w_addr.size(), done_o, MAXW);
    end
    for (int i = 0; i < w_addr.size() && i < MAXW; i++) begin
      checks++;
      if (w_addr[i] !== i || w_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL reload_write[%0d]: addr=%0d data=%h required %0d %h",
                           i, w_addr[i], w_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid_pad();
    logic [15:0] pq[$];
    rand_positions(pq, WT);
    clear_cap();
    pulse_start(15'd77);
    feed(pq, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    checks++;
    if (busy_o !== 1'b1 || ram_wr_en_o !== 1'b1) begin
      errors++; $display("FAIL midpad_pre: busy=%0b wr=%0b required 1 1", busy_o, ram_wr_en_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pos_ready_o, ram_wr_en_o, ram_addr_o, ram_wdata_o, busy_o, done_o, error_o} !== 29'd0) begin
      errors++; $display("FAIL midpad_async: got %h required 0",
                         {pos_ready_o, ram_wr_en_o, ram_addr_o, ram_wdata_o, busy_o, done_o, error_o});
    end
    @(negedge clk); rst_n = 1'b1;
    clear_cap();
    pos_valid_i = 1'b1; pos_i = 16'd5;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (w_addr.size() !== 0 || pos_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL midpad_idle: writes=%0d rdy=%0b busy=%0b done=%0b required 0 0 0 0",
                         w_addr.size(), pos_ready_o, busy_o, done_o);
    end
    pos_valid_i = 1'b0;
  endtask

  task automatic test_start_during_load();
    logic [15:0] pq[$];
    logic [15:0] pa[$];
    logic [15:0] pb[$];
    rand_positions(pq, WT);
    pa.delete(); pb.delete();
    for (int i = 0; i < WT; i++) begin
      if (i < 30) pa.push_back(pq[i]); else pb.push_back(pq[i]);
    end
    build_exp(15'h1234, pq);
    clear_cap();
    pulse_start(15'h1234);
    feed(pa, 0);
    pulse_start(15'h7FFF);
    checks++;
    if (busy_o !== 1'b1 || pos_ready_o !== 1'b1) begin
      errors++; $display("FAIL sdl_state: busy=%0b rdy=%0b required 1 1", busy_o, pos_ready_o);
    end
    feed(pb, 0);
    wait_end();
    checks++;
    if (w_addr.size() !== MAXW || done_o !== 1'b1) begin
      errors++; $display("FAIL sdl_count: writes=%0d done=%0b required %0d 1", w_addr.size(), done_o, MAXW);
    end
    for (int i = 0; i < w_addr.size() && i < MAXW; i++) begin
      checks++;
      if (w_addr[i] !== i || w_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL sdl_write[%0d]: addr=%0d data=%h required %0d %h",
                           i, w_addr[i], w_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] pq[$];
    logic [14:0] s;
    for (int r = 0; r < 3; r++) begin
      rand_positions(pq, WT);
      s = 15'($urandom);
      build_exp(s, pq);
      clear_cap();
      pulse_start(s);
      feed(pq, 2);
      wait_end();
      checks++;
      if (w_addr.size() !== MAXW || done_o !== 1'b1) begin
        errors++; $display("FAIL rand%0d_count: writes=%0d done=%0b required %0d 1",
                           r, w_addr.size(), done_o, MAXW);
      end
      for (int i = 0; i < w_addr.size() && i < MAXW; i++) begin
        checks++;
        if (w_addr[i] !== i || w_data[i] !== exp_data[i] ||
            w_cyc[i] !== ((i < WT) ? acc_q[i] + 1 : w_cyc[i-1] + 1)) begin
          errors++;
          $display("FAIL rand%0d_write[%0d]: addr=%0d data=%h cyc=%0d required addr=%0d data=%h",
                   r, i, w_addr[i], w_data[i], w_cyc[i], i, exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_max();
    test_gaps();
    test_error();
    test_reset_mid_pad();
    test_start_during_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sparse_pos_loader.md
Name: sparse_pos_loader

Overview:
- Upstream stage of the sparse polynomial multiplier.
- Accepts the WEIGHT real nonzero positions of the sparse operand over a valid/ready stream and range-checks each one against N.
- Writes them into the multiplier's position RAM, then pads the RAM to MAX_WEIGHT entries with LFSR-generated dummy positions tagged by a flag bit.
- The multiplier always iterates a constant MAX_WEIGHT entries, independent of the real weight.

Parameters:
- MAX_WEIGHT, 75, total position-RAM entries written per load.
- WEIGHT, 66, number of real positions accepted; constraint 1 <= WEIGHT <= MAX_WEIGHT.
- N, 17669, polynomial length; every real and dummy position must be < N.
- LOGW, 16, width of one position field.
- LFSR_W, 15, dummy-LFSR width; constraint 2^(LFSR_W-1) < N <= 2^LFSR_W and LFSR_W <= LOGW.
- ADDR_W, 7, position-RAM address width, equal to clog2(MAX_WEIGHT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR.
- seed_i  in  LFSR_W  dummy-LFSR seed, sampled on an accepted start_i.
- pos_valid_i  in  1  a real position is presented on pos_i.
- pos_i  in  LOGW  real position value.
- pos_ready_o  out  1  block can accept a position.
- ram_wr_en_o  out  1  position-RAM write strobe.
- ram_addr_o  out  ADDR_W  position-RAM address.
- ram_wdata_o  out  LOGW+1  write data: bit LOGW is the dummy flag, bits LOGW-1:0 are the position.
- busy_o  out  1  high in LOAD and PAD.
- done_o  out  1  high in DONE.
- error_o  out  1  high in ERR.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; counter 0; LFSR 1. Reset mid-load aborts the load; writes already issued are not undone.
- States: IDLE, LOAD, PAD, DONE, ERR.
- IDLE/DONE/ERR + start_i:
  - Go to LOAD; clear the address counter; clear done_o and error_o.
  - Load the LFSR with seed_i; a seed of 0 is replaced by 1.
- start_i while in LOAD or PAD is ignored.
- LOAD:
  - pos_ready_o is driven combinationally high in LOAD only.
  - Accept occurs when pos_valid_i and pos_ready_o are both high.
  - If pos_i < N: the next cycle drives ram_wr_en_o=1, ram_addr_o=counter, ram_wdata_o={1'b0,pos_i}; the counter then increments. Registered write, latency 1 cycle from accept.
  - The WEIGHT-th valid accept moves to PAD, or directly to DONE when WEIGHT == MAX_WEIGHT.
  - If pos_i >= N on an accept: no write; go to ERR; error_o=1 next cycle; the counter is frozen.
  - Back-to-back accepts are supported: one write per cycle, no bubbles.
- PAD:
  - One dummy write per cycle for addresses WEIGHT..MAX_WEIGHT-1, with wdata={1'b1, zero-extended d}.
  - d = lfsr if lfsr < N, else lfsr - N. A single subtract is sufficient given the LFSR_W constraint.
  - After each dummy write the LFSR advances: lfsr <= {lfsr[LFSR_W-2:0], lfsr[14]^lfsr[13]}; taps x^15+x^14+1 for the default width.
  - After the write to address MAX_WEIGHT-1, go to DONE.
  - The LFSR never advances outside PAD.
- DONE: done_o=1 held until the next accepted start_i; ram_wr_en_o=0.
- ERR: error_o=1, pos_ready_o=0, no writes; exit only via start_i or reset.
- ram_wr_en_o is high for exactly MAX_WEIGHT cycles per successful load; addresses are strictly increasing with no wrap.
- busy_o is high from the cycle after an accepted start_i until the DONE/ERR transition; busy_o, done_o and error_o are mutually exclusive.

Test Plan:
- Reset, then start_i with seed_i=1, then 66 back-to-back positions 0..65 -> 66 writes at addresses 0..65 with flag 0, then 9 dummy writes at addresses 66..74 with data {1,1},{1,2},{1,4}...{1,256}; done_o=1; total write cycles=75.
- seed_i=0x7FFF, pad phase -> first dummy position 32767-17669=15098 with flag 1; second dummy from LFSR 0x7FFE gives 15097.
- pos_valid_i toggled every other cycle with positions 17668 and 0 -> both accepted, writes occur 1 cycle after each accept, no writes during gaps.
- 10th position = 17669 -> no write for it, error_o=1, pos_ready_o=0, writes stop at address 8; a new start_i clears error_o and restarts at address 0.
- rst_n asserted low in the middle of PAD -> outputs 0 immediately (asynchronously); after release the block is in IDLE and ignores pos_valid_i.
- start_i pulsed during LOAD -> ignored; counter and LFSR unchanged; the load completes normally.
